instr_fetch: RTL and testbench

Fetch stage of the 16-bit pipelined core: holds the PC, issues instruction-memory reads, and buffers fetched words in a 2-entry queue that feeds the decode stage. It produces the 16-bit instruction word and its PC, from which decode takes `instruction[10:0]` and the PC's upper bits. It honours decode back-pressure (`stall`), redirects from branch/jump resolution, and stops fetching on HALT.

---
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 16-bit core.
// Holds the PC, issues instruction-memory reads, and buffers fetched words
// in a 2-entry {instr, pc} queue that feeds decode.
// Optional macro FETCH_BYPASS_EN: an ack landing on an empty queue is
// presented to decode in the same cycle (zero-latency fetch).
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_ERR} state_t;

  state_t            state, state_nx;
  logic [15:0]       pc;
  logic [1:0]        cnt;
  logic              wr_ptr, rd_ptr;
  logic [1:0][15:0]  q_instr;
  logic [1:0][15:0]  q_pc;

  logic fire, redir, accept, push, pop, halt_word;

  // Request is gated by rst so it drops the instant reset asserts.
  assign imem_req  = rst & (state == S_RUN) & (cnt < 2'd2);
  assign imem_addr = pc;
  assign fire      = imem_req & imem_ack;
  // ERR ignores redirects; only reset leaves it.
  assign redir     = redirect & (state != S_ERR);
  // A word is captured (PC advances) only when no redirect wins the cycle.
  assign accept    = fire & ~redir;
  assign halt_word = (imem_data[15:11] == 5'b00000);
  assign halted    = (state == S_HALT);
  assign err       = (state == S_ERR);

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp = (cnt == 2'd0) & accept;

  // Empty queue: a same-cycle ack is forwarded straight to decode.
  always_comb begin
    instr_valid = (cnt != 2'd0) | byp;
    instr       = q_instr[rd_ptr];
    instr_pc    = q_pc[rd_ptr];
    if (byp) begin
      instr    = imem_data;
      instr_pc = pc;
    end
  end

  // A bypassed word that decode accepts never enters the queue.
  assign push = accept & ~(byp & ~stall);
  assign pop  = (cnt != 2'd0) & ~stall;
`else
  assign instr_valid = (cnt != 2'd0);
  assign instr       = q_instr[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];
  assign push        = accept;
  assign pop         = instr_valid & ~stall;
`endif

  // Next state: redirect restarts fetch (or traps on an odd target); a
  // captured HALT opcode stops further requests.
  always_comb begin
    state_nx = state;
    if (redir)
      state_nx = redirect_pc[0] ? S_ERR : S_RUN;
    else if ((state == S_RUN) && accept && halt_word)
      state_nx = S_HALT;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nx;
  end

  // PC and queue: redirect flushes and reloads the PC, otherwise push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      cnt     <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      q_instr <= '0;
      q_pc    <= '0;
    end else if (redir) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      if (!redirect_pc[0]) pc <= redirect_pc;
    end else begin
      if (accept) pc <= pc + 16'd2;
      if (push) begin
        q_instr[wr_ptr] <= imem_data;
        q_pc[wr_ptr]    <= pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch (default, registered build)
// against a behavioural instruction memory returning 16'h4000 + addr.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        err;

  int vecs = 0;
  int errs = 0;

  // memory model controls
  logic       ack_en    = 1'b0;
  logic       rand_mode = 1'b0;
  logic       halt_en   = 1'b0;
  logic [1:0] wait_cnt  = 2'd0;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  assign imem_ack  = ack_en & imem_req & (!rand_mode || wait_cnt == 2'd0);
  assign imem_data = (halt_en && imem_addr == 16'h0008) ? 16'h0000
                                                        : 16'h4000 + imem_addr;

  // random 0..3 cycle latency per transaction
  always @(posedge clk) begin
    if (imem_req && imem_ack) wait_cnt <= 2'($urandom_range(0, 3));
    else if (imem_req && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_pc;
    int          delivered;
    int          cyc;
    logic        saw_wrap;

    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    ack_en = 1'b1;
    #12;
    // reset values
    chk("rst_req",    {15'b0, imem_req},    16'd0);
    chk("rst_valid",  {15'b0, instr_valid}, 16'd0);
    chk("rst_instr",  instr,                16'h0000);
    chk("rst_pc",     instr_pc,             16'h0000);
    chk("rst_addr",   imem_addr,            16'h0000);
    chk("rst_halted", {15'b0, halted},      16'd0);
    chk("rst_err",    {15'b0, err},         16'd0);

    // ---- zero-wait streaming ----
    @(negedge clk); rst = 1'b1; #1;
    chk("req_on_release", {15'b0, imem_req}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("stream_valid", {15'b0, instr_valid}, 16'd1);
      chk("stream_pc",    instr_pc, 16'(2 * k));
      chk("stream_instr", instr,    16'h4000 + 16'(2 * k));
    end

    // ---- stall fills the queue ----
    @(negedge clk); rst = 1'b0; stall = 1'b1; #1; rst = 1'b1; #1;
    chk("st_c0_addr", imem_addr, 16'h0000);
    tick;  // cycle 1
    chk("st_c1_pc",   instr_pc, 16'h0000);
    chk("st_c1_addr", imem_addr, 16'h0002);
    for (int k = 2; k < 5; k++) begin
      tick;
      chk("st_full_req",  {15'b0, imem_req}, 16'd0);
      chk("st_full_addr", imem_addr, 16'h0004);
      chk("st_full_head", instr_pc,  16'h0000);
    end
    @(negedge clk); stall = 1'b0; #1;  // cycle 5
    chk("rel_c5_pc",  instr_pc, 16'h0000);
    chk("rel_c5_req", {15'b0, imem_req}, 16'd0);
    tick;  // cycle 6
    chk("rel_c6_pc",  instr_pc, 16'h0002);
    chk("rel_c6_req", {15'b0, imem_req}, 16'd1);
    chk("rel_c6_addr", imem_addr, 16'h0004);
    tick;  // cycle 7
    chk("rel_c7_pc",   instr_pc, 16'h0004);
    chk("rel_c7_addr", imem_addr, 16'h0006);

    // ---- redirect racing an ack for addr 6 ----
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick; redirect = 1'b0;  // cycle 8
    chk("redir_valid", {15'b0, instr_valid}, 16'd0);
    chk("redir_addr",  imem_addr, 16'h0100);
    tick;  // cycle 9
    chk("redir_pc",    instr_pc, 16'h0100);
    chk("redir_instr", instr,    16'h4100);

    // ---- HALT word at addr 8 ----
    halt_en = 1'b1; redirect = 1'b1; redirect_pc = 16'h0008;
    tick; redirect = 1'b0;  // cycle 10
    chk("h_c10_addr", imem_addr, 16'h0008);
    tick;  // cycle 11
    chk("h_halted",  {15'b0, halted},      16'd1);
    chk("h_req",     {15'b0, imem_req},    16'd0);
    chk("h_valid",   {15'b0, instr_valid}, 16'd1);
    chk("h_instr",   instr,    16'h0000);
    chk("h_pc",      instr_pc, 16'h0008);
    tick;  // cycle 12
    chk("h_drain_valid", {15'b0, instr_valid}, 16'd0);
    chk("h_still_req",   {15'b0, imem_req},    16'd0);
    halt_en = 1'b0; redirect = 1'b1; redirect_pc = 16'h0020;
    tick; redirect = 1'b0;  // cycle 13
    chk("resume_halted", {15'b0, halted},   16'd0);
    chk("resume_req",    {15'b0, imem_req}, 16'd1);
    chk("resume_addr",   imem_addr, 16'h0020);
    tick;  // cycle 14
    chk("resume_pc", instr_pc, 16'h0020);

    // ---- odd redirect -> ERR ----
    redirect = 1'b1; redirect_pc = 16'h0101;
    tick; redirect = 1'b0;  // cycle 15
    chk("err_flag",  {15'b0, err},         16'd1);
    chk("err_req",   {15'b0, imem_req},    16'd0);
    chk("err_valid", {15'b0, instr_valid}, 16'd0);
    chk("err_addr",  imem_addr, 16'h0022);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick; redirect = 1'b0;
    chk("err_sticky", {15'b0, err},      16'd1);
    chk("err_noreq",  {15'b0, imem_req}, 16'd0);
    tick;
    chk("err_hold_addr", imem_addr, 16'h0022);

    // ---- asynchronous reset mid-cycle ----
    @(negedge clk); #2; rst = 1'b0; #1;
    chk("arst_err",    {15'b0, err},         16'd0);
    chk("arst_req",    {15'b0, imem_req},    16'd0);
    chk("arst_valid",  {15'b0, instr_valid}, 16'd0);
    chk("arst_addr",   imem_addr, 16'h0000);
    chk("arst_instr",  instr,     16'h0000);
    chk("arst_pc",     instr_pc,  16'h0000);
    chk("arst_halted", {15'b0, halted}, 16'd0);

    // ---- random latency, random stall, PC wrap ----
    rand_mode = 1'b1;
    @(negedge clk); rst = 1'b1; redirect = 1'b1; redirect_pc = 16'hFF00;
    tick; redirect = 1'b0;
    exp_pc = 16'hFF00; delivered = 0; cyc = 0; saw_wrap = 1'b0;
    while (delivered < 200 && cyc < 3000) begin
      stall = ($urandom_range(0, 3) == 0);
      #1;
      if (instr_valid && !stall) begin
        chk("rnd_pc",    instr_pc, exp_pc);
        chk("rnd_instr", instr,    16'h4000 + exp_pc);
        if (exp_pc == 16'h0000 && instr_pc == 16'h0000) saw_wrap = 1'b1;
        exp_pc = exp_pc + 16'd2;
        delivered++;
      end
      tick;
      cyc++;
    end
    stall = 1'b0;
    chk("rnd_count", 16'(delivered), 16'd200);
    chk("rnd_wrap",  {15'b0, saw_wrap}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
